// File: rtl/pulse_meter_if.sv
// Result/handshake bundle between pulse_meter and its consumer.
// The master side drives the waveform, the enable and the ack; the slave side is the meter.
interface pulse_meter_if #(
   parameter int unsigned CW = 16,
   parameter int unsigned EW = 8
);
   logic          signal;
   logic          enable;
   logic          ack;
   logic [CW-1:0] high_cycles;
   logic [CW-1:0] period_cycles;
   logic          valid;
   logic          overflow;
   logic [EW-1:0] edge_count;

   modport master (
      output signal, enable, ack,
      input  high_cycles, period_cycles, valid, overflow, edge_count
   );

   modport slave (
      input  signal, enable, ack,
      output high_cycles, period_cycles, valid, overflow, edge_count
   );
endinterface

// File: rtl/pulse_meter.sv
// Measures high time and period of an asynchronous pulse input, in clock cycles.
// Each result is held behind a valid/ack handshake; results arriving while one is pending are dropped.
module pulse_meter #(
   parameter int unsigned CW   = 16,
   parameter int unsigned SYNC = 2,
   parameter int unsigned EW   = 8
) (
   input  logic        clock,
   input  logic        reset,
   pulse_meter_if.slave bus_io
);

   typedef enum logic [1:0] {StIdle, StArmed, StMeas} state_e;

   localparam logic [CW-1:0] CntMax = '1;
   localparam logic [CW-1:0] CntOne = CW'(1);

   state_e          state_q, state_d;
   logic [SYNC-1:0] sync_q;
   logic            s, s_d_q, rise;
   logic [CW-1:0]   per_cnt_q, per_cnt_d;
   logic [CW-1:0]   hi_cnt_q, hi_cnt_d;
   logic [CW-1:0]   high_q, high_d;
   logic [CW-1:0]   period_q, period_d;
   logic            valid_q, valid_d;
   logic            ovf_q, ovf_d;
   logic [EW-1:0]   edge_q, edge_d;
   logic            done;

   assign s    = sync_q[SYNC-1];
   assign rise = s & ~s_d_q;

   always_comb begin
      state_d   = state_q;
      per_cnt_d = per_cnt_q;
      hi_cnt_d  = hi_cnt_q;
      edge_d    = edge_q;
      done      = 1'b0;
      if (!bus_io.enable) begin
         // Disabling abandons the partial period; latched results are kept.
         state_d   = StIdle;
         per_cnt_d = '0;
         hi_cnt_d  = '0;
      end else begin
         unique case (state_q)
            StIdle: state_d = StArmed;
            StArmed: begin
               if (rise) begin
                  state_d   = StMeas;
                  per_cnt_d = CntOne;
                  hi_cnt_d  = CntOne;
                  edge_d    = edge_q + 1'b1;
               end
            end
            StMeas: begin
               if (rise) begin
                  done      = 1'b1;
                  per_cnt_d = CntOne;
                  hi_cnt_d  = CntOne;
                  edge_d    = edge_q + 1'b1;
               end else begin
                  if (per_cnt_q != CntMax) per_cnt_d = per_cnt_q + 1'b1;
                  if (s && hi_cnt_q != CntMax) hi_cnt_d = hi_cnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      high_d   = high_q;
      period_d = period_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      if (done) begin
         if (!valid_q || bus_io.ack) begin
            high_d   = hi_cnt_q;
            period_d = per_cnt_q;
            valid_d  = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && bus_io.ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         sync_q    <= '0;
         s_d_q     <= 1'b0;
         per_cnt_q <= '0;
         hi_cnt_q  <= '0;
         high_q    <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         edge_q    <= '0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[SYNC-2:0], bus_io.signal};
         s_d_q     <= s;
         per_cnt_q <= per_cnt_d;
         hi_cnt_q  <= hi_cnt_d;
         high_q    <= high_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         edge_q    <= edge_d;
      end
   end

   assign bus_io.high_cycles   = high_q;
   assign bus_io.period_cycles = period_q;
   assign bus_io.valid         = valid_q;
   assign bus_io.overflow      = ovf_q;
   assign bus_io.edge_count    = edge_q;

endmodule
